// File: rtl/calc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the limited-function calculator CPU.
// Drives the datapath selects and write strobes, counts retired instructions and latches faults.
module calc_seq_ctrl #(
    parameter logic [31:0] PC_STEP       = 32'd1,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [34:0] imem_data,
    output logic [15:0] imm_a,
    output logic [15:0] imm_b,
    output logic        novel_op_sel,
    output logic        subtract,
    output logic        accum_we,
    output logic        pc_we,
    output logic [31:0] pc_inc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_ADDA = 3'b011;
    localparam logic [2:0] OP_SUBA = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam int              TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    // Returns {legal, writes accumulator, novel_op_sel, subtract}; 101/110 are illegal.
    function automatic logic [3:0] decode_ctl(input logic [2:0] op);
        logic [3:0] ctl;
        case (op)
            OP_NOP:  ctl = 4'b1000;
            OP_ADDI: ctl = 4'b1110;
            OP_SUBI: ctl = 4'b1111;
            OP_ADDA: ctl = 4'b1100;
            OP_SUBA: ctl = 4'b1101;
            OP_HALT: ctl = 4'b1000;
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

    state_t          r_state;
    logic [34:0]     r_instr;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_imem_req;
    logic [15:0]     r_imm_a;
    logic [15:0]     r_imm_b;
    logic            r_sel;
    logic            r_sub;
    logic            r_accum_we;
    logic            r_pc_we;
    logic            r_busy;
    logic            r_halted;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic [31:0]     r_retired;

    logic [2:0]      w_op;
    logic [3:0]      w_dec;
    logic            w_to_last;

    assign w_op      = r_instr[34:32];
    assign w_dec     = decode_ctl(w_op);
    assign w_to_last = (r_to_cnt == TO_LAST);

    // Sequencer: state, latched instruction, timeout counter and every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_instr      <= 35'd0;
            r_to_cnt     <= '0;
            r_imem_req   <= 1'b0;
            r_imm_a      <= 16'd0;
            r_imm_b      <= 16'd0;
            r_sel        <= 1'b0;
            r_sub        <= 1'b0;
            r_accum_we   <= 1'b0;
            r_pc_we      <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_retired    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_to_cnt   <= '0;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    // A valid beat on the timeout cycle still counts as a fetch.
                    if (imem_valid) begin
                        r_instr    <= imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end else if (w_to_last) begin
                        r_imem_req   <= 1'b0;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_TIMEOUT;
                        r_state      <= ST_FAULT;
                    end else begin
                        r_to_cnt   <= r_to_cnt + TO_ONE;
                    end
                end
                ST_DECODE: begin
                    if (w_dec[3]) begin
                        r_imm_a    <= r_instr[31:16];
                        r_imm_b    <= r_instr[15:0];
                        r_accum_we <= w_dec[2];
                        r_sel      <= w_dec[1];
                        r_sub      <= w_dec[0];
                        r_pc_we    <= 1'b1;
                        r_state    <= ST_EXEC;
                    end else begin
                        r_sel        <= 1'b0;
                        r_sub        <= 1'b0;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_ILLEGAL;
                        r_state      <= ST_FAULT;
                    end
                end
                ST_EXEC: begin
                    r_pc_we    <= 1'b0;
                    r_accum_we <= 1'b0;
                    r_sel      <= 1'b0;
                    r_sub      <= 1'b0;
                    r_retired  <= r_retired + 32'd1;
                    if (w_op == OP_HALT) begin
                        r_busy     <= 1'b0;
                        r_halted   <= 1'b1;
                        r_state    <= ST_HALTED;
                    end else begin
                        r_imem_req <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        r_halted   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state    <= ST_HALTED;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    // Corrupted state encoding: drop every strobe and park in IDLE.
                    r_state      <= ST_IDLE;
                    r_imem_req   <= 1'b0;
                    r_sel        <= 1'b0;
                    r_sub        <= 1'b0;
                    r_accum_we   <= 1'b0;
                    r_pc_we      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_halted     <= 1'b0;
                    r_fault      <= 1'b0;
                    r_fault_code <= 2'b00;
                    r_to_cnt     <= '0;
                end
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imm_a        = r_imm_a;
    assign imm_b        = r_imm_b;
    assign novel_op_sel = r_sel;
    assign subtract     = r_sub;
    assign accum_we     = r_accum_we;
    assign pc_we        = r_pc_we;
    assign pc_inc       = PC_STEP;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign fault        = r_fault;
    assign fault_code   = r_fault_code;
    assign retired      = r_retired;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized bench for calc_seq_ctrl: a program-level model expands each instruction into
// its expected cycle trace (fetch waits, decode, execute, halt/fault) and checks every cycle.
module tb_calc_seq_ctrl;

    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic        imem_valid;
    logic [34:0] imem_data;
    logic [15:0] imm_a;
    logic [15:0] imm_b;
    logic        novel_op_sel;
    logic        subtract;
    logic        accum_we;
    logic        pc_we;
    logic [31:0] pc_inc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    always #5 clk = ~clk;

    calc_seq_ctrl #(.PC_STEP(32'd1), .FETCH_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_valid(imem_valid), .imem_data(imem_data),
        .imm_a(imm_a), .imm_b(imm_b), .novel_op_sel(novel_op_sel), .subtract(subtract),
        .accum_we(accum_we), .pc_we(pc_we), .pc_inc(pc_inc),
        .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code),
        .retired(retired)
    );

    typedef struct packed {
        logic        req;
        logic        busy;
        logic        halted;
        logic        fault;
        logic [1:0]  code;
        logic        pcwe;
        logic        accwe;
        logic [31:0] ret;
        logic        chk_ss;
        logic        sel;
        logic        sub;
        logic        chk_imm;
        logic [15:0] ia;
        logic [15:0] ib;
        logic        in_start;
        logic        in_valid;
        logic [34:0] in_data;
        logic        do_reset;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;

    // Architectural model state: retirements, last decoded immediates, idle/halted/fault mode.
    logic [31:0] m_ret;
    logic [15:0] m_ia;
    logic [15:0] m_ib;
    int          m_mode;
    logic [1:0]  m_code;
    logic        m_imm_ok;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [34:0] rand_word();
        logic [34:0] w;
        w = {3'($urandom), 16'($urandom), 16'($urandom)};
        return w;
    endfunction

    task automatic model_reset();
        m_ret    = 32'd0;
        m_ia     = 16'd0;
        m_ib     = 16'd0;
        m_mode   = 0;
        m_code   = 2'b00;
        m_imm_ok = 1'b1;
    endtask

    task automatic push_rest(input logic st);
        cyc_t c;
        c          = '0;
        c.halted   = (m_mode == 1);
        c.fault    = (m_mode == 2);
        c.code     = m_code;
        c.ret      = m_ret;
        c.chk_ss   = 1'b1;
        c.chk_imm  = m_imm_ok;
        c.ia       = m_ia;
        c.ib       = m_ib;
        c.in_start = st;
        c.in_valid = 1'($urandom);
        c.in_data  = rand_word();
        exp_q.push_back(c);
    endtask

    task automatic rest(input int n);
        for (int i = 0; i < n; i++) push_rest(1'b0);
    endtask

    task automatic reset_now();
        exp_q[exp_q.size()-1].do_reset = 1'b1;
        model_reset();
    endtask

    // One instruction: w idle-memory cycles before valid (w >= FT means memory never answers).
    task automatic instr(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int w, input logic start_last, input logic rst_dec);
        cyc_t c;
        int   nf;
        nf = (w >= FT) ? FT : w + 1;
        for (int k = 0; k < nf; k++) begin
            c          = '0;
            c.req      = 1'b1;
            c.busy     = 1'b1;
            c.ret      = m_ret;
            c.chk_imm  = m_imm_ok;
            c.ia       = m_ia;
            c.ib       = m_ib;
            c.in_valid = (w < FT) && (k == nf - 1);
            c.in_data  = c.in_valid ? {op, a, b} : rand_word();
            c.in_start = (start_last && (k == nf - 1)) ? 1'b1 : 1'($urandom);
            exp_q.push_back(c);
        end
        if (w >= FT) begin
            m_mode = 2;
            m_code = 2'b10;
            return;
        end
        c          = '0;
        c.busy     = 1'b1;
        c.ret      = m_ret;
        c.in_start = 1'($urandom);
        c.in_valid = 1'($urandom);
        c.in_data  = rand_word();
        c.do_reset = rst_dec;
        exp_q.push_back(c);
        if (rst_dec) begin
            model_reset();
            return;
        end
        if (op == 3'b101 || op == 3'b110) begin
            m_mode   = 2;
            m_code   = 2'b01;
            m_imm_ok = 1'b0;
            return;
        end
        c          = '0;
        c.busy     = 1'b1;
        c.pcwe     = 1'b1;
        c.accwe    = (op >= 3'd1) && (op <= 3'd4);
        c.ret      = m_ret;
        c.chk_ss   = 1'b1;
        c.sel      = (op == 3'd1) || (op == 3'd2);
        c.sub      = (op == 3'd2) || (op == 3'd4);
        c.chk_imm  = 1'b1;
        c.ia       = a;
        c.ib       = b;
        c.in_start = 1'($urandom);
        c.in_valid = 1'($urandom);
        c.in_data  = rand_word();
        exp_q.push_back(c);
        m_ia     = a;
        m_ib     = b;
        m_imm_ok = 1'b1;
        m_ret    = m_ret + 32'd1;
        if (op == 3'b111) m_mode = 1;
    endtask

    task automatic check_async_reset();
        check_val("async_ctl", 32'({imem_req, busy, halted, fault, fault_code, pc_we, accum_we,
                                    novel_op_sel, subtract}), 32'd0);
        check_val("async_ret", retired, 32'd0);
        check_val("async_imm", {imm_a, imm_b}, 32'd0);
    endtask

    task automatic run_trace();
        cyc_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            reset = 1'b0;
            cyc++;
            check_val($sformatf("ctl@%0d", cyc),
                      32'({imem_req, busy, halted, fault, fault_code, pc_we, accum_we}),
                      32'({e.req, e.busy, e.halted, e.fault, e.code, e.pcwe, e.accwe}));
            check_val($sformatf("ret@%0d", cyc), retired, e.ret);
            if (e.chk_ss)
                check_val($sformatf("selsub@%0d", cyc), 32'({novel_op_sel, subtract}),
                          32'({e.sel, e.sub}));
            if (e.chk_imm)
                check_val($sformatf("imm@%0d", cyc), {imm_a, imm_b}, {e.ia, e.ib});
            start      = e.in_start;
            imem_valid = e.in_valid;
            imem_data  = e.in_data;
            if (e.do_reset) begin
                #3;
                reset = 1'b1;
                #1;
                check_async_reset();
            end
        end
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 35'd0;
        model_reset();
        #1;
        check_async_reset();
        check_val("pc_inc", pc_inc, 32'd1);
        repeat (2) @(posedge clk);

        rest(3);
        push_rest(1'b1);
        instr(3'b001, 16'd5, 16'd3, 0, 1'b0, 1'b0);
        instr(3'b111, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        rest(2);
        push_rest(1'b1);
        instr(3'b100, 16'($urandom), 16'($urandom), 2, 1'b0, 1'b0);
        instr(3'b000, 16'($urandom), 16'($urandom), 2, 1'b0, 1'b0);
        instr(3'b111, 16'($urandom), 16'($urandom), 2, 1'b0, 1'b0);
        rest(2);
        repeat (6) begin
            push_rest(1'b1);
            n = $urandom_range(5, 1);
            for (int i = 0; i < n; i++)
                instr(3'($urandom_range(4, 0)), 16'($urandom), 16'($urandom),
                      $urandom_range(4, 0), 1'b0, 1'b0);
            instr(3'b111, 16'($urandom), 16'($urandom), $urandom_range(3, 0), 1'b0, 1'b0);
            rest($urandom_range(3, 0));
        end
        push_rest(1'b1);
        instr(3'b001, 16'($urandom), 16'($urandom), 1, 1'b0, 1'b0);
        instr(3'b110, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) push_rest(1'(i % 2 == 0));
        reset_now();
        rest(2);
        push_rest(1'b1);
        instr(3'b001, 16'($urandom), 16'($urandom), FT, 1'b1, 1'b0);
        rest(3);
        reset_now();
        rest(1);
        push_rest(1'b1);
        instr(3'b010, 16'($urandom), 16'($urandom), FT - 1, 1'b0, 1'b0);
        instr(3'b111, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        rest(1);
        push_rest(1'b1);
        instr(3'b001, 16'd5, 16'd3, 0, 1'b0, 1'b1);
        rest(2);
        push_rest(1'b1);
        instr(3'b101, 16'($urandom), 16'($urandom), 3, 1'b0, 1'b0);
        rest(3);
        reset_now();
        rest(1);
        push_rest(1'b1);
        instr(3'b111, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        rest(1);
        run_trace();

        // Preload the retirement counter just below wrap while halted.
        start = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        rest(2);
        push_rest(1'b1);
        instr(3'b000, 16'($urandom), 16'($urandom), 1, 1'b0, 1'b0);
        instr(3'b111, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        rest(2);
        run_trace();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Multi-cycle control unit for the limited-function calculator CPU. It fetches 35-bit instructions from instruction memory over a valid handshake and decodes the opcode and two 16-bit immediates. It then drives the datapath controls: novel-operation mux select, add/subtract select, accumulator write enable, and PC write enable and step. It also keeps a retired-instruction count and latches fault status.

## Interface
- PC_STEP, 32'd1: value driven on `pc_inc` and added to PC on each `pc_we`.
- FETCH_TIMEOUT, 16: max cycles spent in FETCH without `imem_valid` before entering FAULT; must be ≥1.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  single-cycle pulse; leaves IDLE or HALTED; ignored in all other states.
- imem_req  out  1  fetch request to instruction memory.
- imem_valid  in  1  instruction memory has valid data this cycle.
- imem_data  in  35  instruction: [34:32] opcode, [31:16] immA, [15:0] immB.
- imm_a  out  16  immA to sign-extend A.
- imm_b  out  16  immB to sign-extend B.
- novel_op_sel  out  1  novel-op mux address: 0 = accumulator, 1 = sign-extended immB.
- subtract  out  1  add/subtractor mode: 1 = A − B.
- accum_we  out  1  accumulator write enable.
- pc_we  out  1  PC register write enable.
- pc_inc  out  32  PC adder B operand, constant PC_STEP.
- busy  out  1  high in FETCH, DECODE, EXEC.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- fault_code  out  2  00 none, 01 illegal opcode, 10 fetch timeout.
- retired  out  32  count of completed EXEC cycles; wraps at 2^32−1 → 0.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
- IDLE: all controls low. `start` → FETCH.
- FETCH: `imem_req`=1.
  - `imem_valid`=1 at an edge → latch `imem_data` → DECODE.
  - Timeout counter is cleared on entry and increments each FETCH cycle without valid. On reaching FETCH_TIMEOUT → FAULT with code 10.
- DECODE: register `imm_a`, `imm_b`, `novel_op_sel`, `subtract` from the latched instruction. Opcodes 101 and 110 → FAULT with code 01. Otherwise → EXEC.
- Opcodes:
  - 000 NOP: no accumulator write.
  - 001 ADDI: acc ← A + immB (sel=1, sub=0).
  - 010 SUBI: acc ← A − immB (sel=1, sub=1).
  - 011 ADDA: acc ← A + acc (sel=0, sub=0).
  - 100 SUBA: acc ← A − acc (sel=0, sub=1).
  - 111 HALT: no accumulator write.
- EXEC: exactly one cycle.
  - `pc_we`=1; `accum_we`=1 only for opcodes 001–100; `retired` +1.
  - Next state: HALT → HALTED, else → FETCH.
- HALTED: controls low, `halted`=1; `start` → FETCH at the already-advanced PC.
- FAULT: terminal until reset. Controls low, `fault`=1, `fault_code` held, `start` ignored; PC and accumulator are not written.
- For NOP, HALT and FAULT, `novel_op_sel`/`subtract` are 0.
- `imm_a`/`imm_b` hold their last decoded value outside DECODE/EXEC.

## Timing
- Reset values: state IDLE; every output 0 except `pc_inc`=PC_STEP; timeout counter 0.
- Reset asserted mid-instruction: the instruction is abandoned with no `accum_we`/`pc_we`.
- Zero-wait memory (`imem_valid` high in the first FETCH cycle): 3 cycles per instruction (FETCH, DECODE, EXEC).
- Each cycle with `imem_valid` low in FETCH adds one cycle.
- `imem_req` rises in the cycle after the `start` edge. It drops in the cycle after valid is sampled.
- Datapath controls (`imm_*`, `novel_op_sel`, `subtract`) are stable from the DECODE edge through the end of EXEC. The add/sub result therefore settles before the `accum_we` edge.
- `accum_we` and `pc_we` are coincident single-cycle pulses, never asserted in consecutive cycles.
- `start` coincident with the final timeout cycle is ignored; FAULT wins.
- `imem_valid` on the same edge as the timeout is reached: valid wins, go to DECODE.
- `imem_valid` outside FETCH is ignored.

## Test plan
- Reset, then `start`; memory returns ADDI immA=5 immB=3 with zero wait → EXEC 3 cycles after FETCH entry; `accum_we`=`pc_we`=1 for one cycle, sel=1, sub=0, imm_a=5, imm_b=3, `retired`=1.
- Program SUBA, NOP, HALT with 2 wait cycles per fetch → `accum_we` only for SUBA (sel=0, sub=1); 3 `pc_we` pulses, 5 cycles apart; `halted`=1; `retired`=3. `start` → next fetch issued.
- Opcode 110 → FAULT, `fault_code`=01, no `accum_we`/`pc_we`, `start` ignored for 10 cycles; reset clears `fault`.
- `imem_valid` held low with FETCH_TIMEOUT=16 → FAULT with code 10 after exactly 16 FETCH cycles; valid arriving on cycle 16 instead → DECODE.
- Reset asserted during DECODE of ADDI → outputs zero asynchronously, no write pulses, state IDLE, `retired`=0.
- Preload `retired`=32'hFFFFFFFF via a run of NOPs (forced) → next EXEC wraps `retired` to 0.
